// File: rtl/redun_mont_pkg.sv
// Shared types, field constants and redundant-form helpers for the Montgomery
// squaring path, plus the fe_mul_mont reference used by benches.
package redun_mont_pkg;

   localparam int DAT_BITS = 16;
   localparam int WRD_BITS = 8;
   localparam int NUM_WRDS = DAT_BITS / WRD_BITS;
   localparam int SUM_BITS = DAT_BITS + 2;

   typedef logic [DAT_BITS-1:0]               fe_t;
   typedef logic [NUM_WRDS-1:0][WRD_BITS:0]   redun0_t;

   localparam fe_t P = 16'd65521;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_OUT
   } sq_state_e;

   function automatic redun0_t to_redun(input fe_t x);
      redun0_t r;
      for (int i = 0; i < NUM_WRDS; i++) begin
         r[i] = {1'b0, x[i*WRD_BITS +: WRD_BITS]};
      end
      return r;
   endfunction

   // Each word carries one spare bit, so the full sum can exceed DAT_BITS.
   function automatic logic [SUM_BITS-1:0] redun_sum(input redun0_t r);
      logic [SUM_BITS-1:0] acc;
      acc = '0;
      for (int i = 0; i < NUM_WRDS; i++) begin
         acc = acc + (SUM_BITS'(r[i]) << (i*WRD_BITS));
      end
      return acc;
   endfunction

   function automatic fe_t from_redun(input redun0_t r);
      logic [SUM_BITS-1:0] s;
      s = redun_sum(r);
      return s[DAT_BITS-1:0];
   endfunction

   function automatic logic check_overflow(input redun0_t r);
      logic [SUM_BITS-1:0] s;
      s = redun_sum(r);
      return s[SUM_BITS-1:DAT_BITS] != '0;
   endfunction

   // Bit-serial Montgomery product a*b*2^-DAT_BITS mod P.
   function automatic fe_t fe_mul_mont(input fe_t a, input fe_t b);
      logic [DAT_BITS+1:0] t;
      t = '0;
      for (int i = 0; i < DAT_BITS; i++) begin
         if (a[i]) t = t + {2'b00, b};
         if (t[0]) t = t + {2'b00, P};
         t = t >> 1;
      end
      if (t >= {2'b00, P}) t = t - {2'b00, P};
      return t[DAT_BITS-1:0];
   endfunction

endpackage

// File: rtl/redun_mont_from_redun_reg.sv
// Single-register carry-resolve stage converting a redundant operand to fe_t.
module redun_mont_from_redun_reg
   import redun_mont_pkg::*;
(
   input  logic    i_clk,
   input  logic    i_rst,
   input  logic    i_en,
   input  redun0_t i_dat,
   output fe_t     o_dat
);

   fe_t dat_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         dat_q <= '0;
      end else if (i_en) begin
         dat_q <= from_redun(i_dat);
      end
   end

   assign o_dat = dat_q;

endmodule

// File: rtl/redun_mont_sq_ctrl.sv
// Repeated Montgomery squaring sequencer around an external redundant-form core.
// Optional overflow/range checking: define REDUN_MONT_SQ_CTRL_OVF_CHECK_EN.
module redun_mont_sq_ctrl
   import redun_mont_pkg::*;
#(
   parameter int T_BITS = 64
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_val,
   output logic              o_rdy,
   input  fe_t               i_dat,
   input  logic [T_BITS-1:0] i_t,
   output logic              o_val,
   input  logic              i_rdy,
   output fe_t               o_dat,
   output logic [T_BITS-1:0] o_iter,
   output logic              o_core_val,
   output redun0_t           o_core_dat,
   input  logic              i_core_val,
   input  redun0_t           i_core_dat,
   output logic              o_err
);

   sq_state_e         state_q;
   redun0_t           opnd_q;
   logic [T_BITS-1:0] cnt_q;
   logic [T_BITS-1:0] iter_q;
   logic [T_BITS-1:0] iter_inc;
   logic              rdy_q;
   logic              val_q;
   logic              core_val_q;
   logic              err_q;
   logic              err_d;
   logic              conv_en;

   assign iter_inc = iter_q + T_BITS'(1);
   // Conversion register loads only on the first OUT cycle, keeping o_dat stable.
   assign conv_en  = (state_q == ST_OUT) && !val_q;

   always_comb begin
      err_d = err_q | (i_core_val && (state_q != ST_WAIT));
`ifdef REDUN_MONT_SQ_CTRL_OVF_CHECK_EN
      if (i_core_val && (state_q == ST_WAIT) && check_overflow(i_core_dat)) err_d = 1'b1;
      if (val_q && (o_dat >= P)) err_d = 1'b1;
`endif
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         opnd_q     <= '0;
         cnt_q      <= '0;
         iter_q     <= '0;
         rdy_q      <= 1'b0;
         val_q      <= 1'b0;
         core_val_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         err_q <= err_d;
         case (state_q)
            ST_IDLE: begin
               rdy_q <= 1'b1;
               if (i_val && rdy_q) begin
                  opnd_q <= to_redun(i_dat);
                  cnt_q  <= i_t;
                  iter_q <= '0;
                  rdy_q  <= 1'b0;
                  if (i_t == '0) begin
                     state_q <= ST_OUT;
                  end else begin
                     state_q    <= ST_ISSUE;
                     core_val_q <= 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               core_val_q <= 1'b0;
               state_q    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (i_core_val) begin
                  opnd_q <= i_core_dat;
                  iter_q <= iter_inc;
                  if (iter_inc == cnt_q) begin
                     state_q <= ST_OUT;
                  end else begin
                     state_q    <= ST_ISSUE;
                     core_val_q <= 1'b1;
                  end
               end
            end
            ST_OUT: begin
               if (!val_q) begin
                  val_q <= 1'b1;
               end else if (i_rdy) begin
                  val_q   <= 1'b0;
                  rdy_q   <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   redun_mont_from_redun_reg u_from_redun (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (conv_en),
      .i_dat (opnd_q),
      .o_dat (o_dat)
   );

   assign o_rdy      = rdy_q;
   assign o_val      = val_q;
   assign o_iter     = iter_q;
   assign o_core_val = core_val_q;
   assign o_core_dat = opnd_q;
   assign o_err      = err_q;

endmodule
